// File: rtl/demux_stream_1_2_pkg.sv
// Shared definitions for the buffered 1:2 stream demultiplexer:
// channel index type and pointer-width helper.
package demux_stream_pkg;

  // Channel index: one bit selects between the two output channels.
  typedef logic chan_sel_t;

  localparam chan_sel_t CHAN_0 = 1'b0;
  localparam chan_sel_t CHAN_1 = 1'b1;

  localparam int NUM_CHAN = 2;

  // Pointer width for a FIFO of the given depth (never narrower than one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux_stream_1_2_if.sv
// Handshake bundle for demux_stream_1_2: one input stream and two output
// channels. The slave modport is the demultiplexer's view; the master
// modport is the view of the surrounding producer/consumers.
interface demux_stream_1_2_if #(
  parameter int DATA_WIDTH = 8
);
  import demux_stream_pkg::*;

  // Input stream
  logic                  Enable_In;
  logic [DATA_WIDTH-1:0] Data_In;
  chan_sel_t             Select_In;
  logic                  Valid_In;
  logic                  Ready_Out;

  // Channel 0
  logic [DATA_WIDTH-1:0] Data_0_Out;
  logic                  Valid_0_Out;
  logic                  Ready_0_In;

  // Channel 1
  logic [DATA_WIDTH-1:0] Data_1_Out;
  logic                  Valid_1_Out;
  logic                  Ready_1_In;

  modport slave (
    input  Enable_In, Data_In, Select_In, Valid_In, Ready_0_In, Ready_1_In,
    output Ready_Out, Data_0_Out, Valid_0_Out, Data_1_Out, Valid_1_Out
  );

  modport master (
    output Enable_In, Data_In, Select_In, Valid_In, Ready_0_In, Ready_1_In,
    input  Ready_Out, Data_0_Out, Valid_0_Out, Data_1_Out, Valid_1_Out
  );

endinterface

// File: rtl/demux_stream_1_2_fifo.sv
// demux_stream_fifo: small synchronous FIFO used once per output channel.
// Head data is read straight from storage so a pushed beat is visible the
// cycle after it is written. Reset clears pointers, count and storage.
module demux_stream_fifo
  import demux_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; writes to a full FIFO and reads of an
  // empty one are ignored so callers cannot corrupt the count.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and storage registers, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/demux_stream_1_2.sv
// demux_stream_1_2: buffered, handshaked 1:2 stream demultiplexer.
// Each beat goes to the channel named by Select_In; each channel has its own
// FIFO so a stalled consumer never blocks or drops data on the other side.
// Optional per-channel push counters: define DEMUX_STREAM_1_2_COUNT_EN.
module demux_stream_1_2
  import demux_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_n_In,
  demux_stream_1_2_if.slave     bus
`ifdef DEMUX_STREAM_1_2_COUNT_EN
  ,
  output logic [15:0]           Count_0_Out,
  output logic [15:0]           Count_1_Out
`endif
);

  logic [NUM_CHAN-1:0]   fifo_full;
  logic [NUM_CHAN-1:0]   fifo_empty;
  logic [NUM_CHAN-1:0]   fifo_push;
  logic [NUM_CHAN-1:0]   fifo_pop;
  logic [NUM_CHAN-1:0]   chan_ready;
  logic [DATA_WIDTH-1:0] fifo_dout [NUM_CHAN];
  logic                  in_ready;
  logic                  accept;

  // Ready depends only on enable and space in the selected FIFO; held low in
  // reset so nothing is offered as accepted while state is being cleared.
  always_comb begin
    in_ready = Reset_n_In & bus.Enable_In & ~fifo_full[bus.Select_In];
    accept   = bus.Valid_In & in_ready;
    fifo_push         = '0;
    fifo_push[CHAN_0] = accept & (bus.Select_In == CHAN_0);
    fifo_push[CHAN_1] = accept & (bus.Select_In == CHAN_1);
  end

  assign chan_ready[CHAN_0] = bus.Ready_0_In;
  assign chan_ready[CHAN_1] = bus.Ready_1_In;

  generate
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      assign fifo_pop[gi] = chan_ready[gi] & ~fifo_empty[gi];

      demux_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
      ) u_fifo (
        .clk     (Clk_In),
        .rst_n   (Reset_n_In),
        .push_i  (fifo_push[gi]),
        .pop_i   (fifo_pop[gi]),
        .data_i  (bus.Data_In),
        .data_o  (fifo_dout[gi]),
        .full_o  (fifo_full[gi]),
        .empty_o (fifo_empty[gi])
      );
    end
  endgenerate

  assign bus.Ready_Out   = in_ready;
  assign bus.Data_0_Out  = fifo_dout[CHAN_0];
  assign bus.Valid_0_Out = ~fifo_empty[CHAN_0];
  assign bus.Data_1_Out  = fifo_dout[CHAN_1];
  assign bus.Valid_1_Out = ~fifo_empty[CHAN_1];

`ifdef DEMUX_STREAM_1_2_COUNT_EN
  logic [15:0] count_q [NUM_CHAN];
  logic [15:0] count_d [NUM_CHAN];

  generate
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_count
      // Free-running push counter; wraps naturally at 16 bits.
      always_comb begin
        count_d[gi] = count_q[gi] + 16'(fifo_push[gi]);
      end

      // Counter register, cleared by reset.
      always_ff @(posedge Clk_In) begin
        if (!Reset_n_In) begin
          count_q[gi] <= '0;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

  assign Count_0_Out = count_q[CHAN_0];
  assign Count_1_Out = count_q[CHAN_1];
`endif

endmodule
